// File: rtl/lwir_stream_packetizer.sv
// lwir_stream_packetizer: buffers the compressor word stream in a FIFO and frames it into header+payload packets.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   valid_in, stream_in   unthrottled 32-bit input words (dropped when the FIFO is full)
//   flush_in              pulse: close the current partial packet
//   m_valid, m_data,
//   m_last, m_ready       ready/valid packet output
//   overflow              sticky: an input word was dropped
//   fifo_count            words currently buffered
// Optional: define LWIR_PKT_CHECKSUM_EN to append an XOR trailer word to every packet.
module lwir_stream_packetizer #(
   parameter int         FIFO_DEPTH    = 64,
   parameter int         PAYLOAD_WORDS = 16,
   parameter logic [7:0] SYNC_BYTE     = 8'hA5
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          valid_in,
   input  logic [31:0]                   stream_in,
   input  logic                          flush_in,
   output logic                          m_valid,
   output logic [31:0]                   m_data,
   output logic                          m_last,
   input  logic                          m_ready,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
`ifdef LWIR_PKT_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, TRAILER} state_t;
   logic [31:0] csum_q, csum_d;
`else
   typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;
`endif
   state_t          state_q, state_d;
   logic [31:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_q, rd_q;
   logic [CW-1:0]   cnt_q, len_q, len_d, wcnt_q, wcnt_d;
   logic [7:0]      seq_q, seq_d;
   logic            flush_q, flush_d, ovf_q;
   logic            wr_en, rd_en;
   logic [31:0]     header;
   // Full is judged by count so a same-cycle read never rescues an incoming word.
   assign wr_en      = valid_in && (cnt_q != CW'(FIFO_DEPTH));
   assign rd_en      = (state_q == PAYLOAD) && m_ready;
   assign header     = {SYNC_BYTE, seq_q, 16'(len_q)};
   assign overflow   = ovf_q;
   assign fifo_count = cnt_q;
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      wcnt_d  = wcnt_q;
      seq_d   = seq_q;
      flush_d = flush_q | flush_in;
      m_valid = state_q != IDLE;
      m_data  = '0;
      m_last  = 1'b0;
`ifdef LWIR_PKT_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         IDLE: begin
            if (cnt_q >= CW'(PAYLOAD_WORDS)) begin
               len_d   = CW'(PAYLOAD_WORDS);
               state_d = HEADER;
            end else if (flush_q) begin
               flush_d = 1'b0;
               if (cnt_q != '0) begin
                  len_d   = cnt_q;
                  state_d = HEADER;
               end
            end
         end
         HEADER: begin
            m_data = header;
            if (m_ready) begin
               state_d = PAYLOAD;
               wcnt_d  = len_q;
`ifdef LWIR_PKT_CHECKSUM_EN
               csum_d  = header;
`endif
            end
         end
         PAYLOAD: begin
            m_data = mem[rd_q];
`ifdef LWIR_PKT_CHECKSUM_EN
            if (m_ready) begin
               wcnt_d = wcnt_q - CW'(1);
               csum_d = csum_q ^ mem[rd_q];
               if (wcnt_q == CW'(1)) state_d = TRAILER;
            end
`else
            m_last = wcnt_q == CW'(1);
            if (m_ready) begin
               wcnt_d = wcnt_q - CW'(1);
               if (wcnt_q == CW'(1)) begin
                  state_d = IDLE;
                  seq_d   = seq_q + 8'd1;
               end
            end
`endif
         end
`ifdef LWIR_PKT_CHECKSUM_EN
         TRAILER: begin
            m_data = csum_q;
            m_last = 1'b1;
            if (m_ready) begin
               state_d = IDLE;
               seq_d   = seq_q + 8'd1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         wcnt_q  <= '0;
         seq_q   <= '0;
         flush_q <= 1'b0;
         ovf_q   <= 1'b0;
`ifdef LWIR_PKT_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         wr_q    <= wr_en ? wr_q + AW'(1) : wr_q;
         rd_q    <= rd_en ? rd_q + AW'(1) : rd_q;
         cnt_q   <= cnt_q + CW'(wr_en) - CW'(rd_en);
         len_q   <= len_d;
         wcnt_q  <= wcnt_d;
         seq_q   <= seq_d;
         flush_q <= flush_d;
         ovf_q   <= ovf_q | (valid_in && !wr_en);
`ifdef LWIR_PKT_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_q] <= stream_in;
   end
endmodule

// File: tb/tb_lwir_stream_packetizer.sv
// tb_lwir_stream_packetizer: directed self-checking bench for lwir_stream_packetizer.
module tb_lwir_stream_packetizer;
   logic        clk = 1'b0;
   logic        rst_n, valid_in, flush_in, m_ready;
   logic [31:0] stream_in;
   logic        m_valid, m_last, overflow;
   logic [31:0] m_data;
   logic [6:0]  fifo_count;
   int          n_chk = 0;
   int          n_fail = 0;

   typedef struct {
      logic        vin;
      logic [31:0] din;
      logic        fl;
      logic        rdy;
      logic        ev;
      logic [31:0] ed;
      logic        el;
      logic [6:0]  ec;
   } vec_t;
   vec_t vq[$];

   lwir_stream_packetizer dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .stream_in(stream_in),
      .flush_in(flush_in), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
      .m_ready(m_ready), .overflow(overflow), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; valid_in = 1'b0; flush_in = 1'b0; m_ready = 1'b0; stream_in = '0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic feed(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         valid_in = 1'b1;
         stream_in = base + 32'(i);
         tick();
      end
      valid_in = 1'b0;
   endtask

   task automatic flush_pulse();
      flush_in = 1'b1;
      tick();
      flush_in = 1'b0;
   endtask

   // Waits (bounded) for m_valid, checks the word, then lets it handshake (m_ready must be 1).
   task automatic expect_word(input string nm, input logic [31:0] d, input logic l);
      int t = 0;
      while (!m_valid && t < 100) begin
         tick();
         t++;
      end
      chk({nm, " valid"}, 32'(m_valid), 32'd1);
      chk({nm, " data"}, m_data, d);
      chk({nm, " last"}, 32'(m_last), 32'(l));
      tick();
   endtask

   task automatic expect_packet(input string nm, input logic [7:0] seq, input int n, input logic [31:0] base);
      logic [31:0] h, x;
      h = {8'hA5, seq, 16'(n)};
      x = h;
      expect_word({nm, " hdr"}, h, 1'b0);
      for (int i = 0; i < n; i++) begin
         x = x ^ (base + 32'(i));
`ifdef LWIR_PKT_CHECKSUM_EN
         expect_word({nm, " pay"}, base + 32'(i), 1'b0);
`else
         expect_word({nm, " pay"}, base + 32'(i), i == n - 1);
`endif
      end
`ifdef LWIR_PKT_CHECKSUM_EN
      expect_word({nm, " trl"}, x, 1'b1);
`endif
   endtask

   task automatic stall(input string nm, input logic [31:0] d, input logic l, input int n);
      m_ready = 1'b0;
      for (int i = 0; i < n; i++) begin
         tick();
         chk({nm, " valid"}, 32'(m_valid), 32'd1);
         chk({nm, " data"}, m_data, d);
         chk({nm, " last"}, 32'(m_last), 32'(l));
      end
      m_ready = 1'b1;
   endtask

   function automatic void add(input logic vin, input logic [31:0] din, input logic ev,
                               input logic [31:0] ed, input logic el, input logic [6:0] ec);
      vec_t v;
      v.vin = vin; v.din = din; v.fl = 1'b0; v.rdy = 1'b1;
      v.ev = ev; v.ed = ed; v.el = el; v.ec = ec;
      vq.push_back(v);
   endfunction

   initial begin
      logic [31:0] x;
      // Cycle-exact two-packet stream: header lands two cycles after the 16th word.
      for (int i = 0; i < 16; i++) add(1'b1, 32'(i + 1), 1'b0, '0, 1'b0, 7'(i + 1));
      add(1'b0, '0, 1'b1, 32'hA5000010, 1'b0, 7'd16);
      for (int k = 0; k < 16; k++) add(1'b1, 32'h11 + 32'(k), 1'b1, 32'(k + 1), k == 15, 7'd17);
      add(1'b0, '0, 1'b0, '0, 1'b0, 7'd16);
      add(1'b0, '0, 1'b1, 32'hA5010010, 1'b0, 7'd16);
      for (int j = 0; j < 16; j++) add(1'b0, '0, 1'b1, 32'h11 + 32'(j), j == 15, 7'(16 - j));
      add(1'b0, '0, 1'b0, '0, 1'b0, 7'd0);

      do_reset();
      chk("reset valid", 32'(m_valid), 32'd0);
      chk("reset data", m_data, 32'd0);
      chk("reset last", 32'(m_last), 32'd0);
      chk("reset overflow", 32'(overflow), 32'd0);
      chk("reset count", 32'(fifo_count), 32'd0);

`ifndef LWIR_PKT_CHECKSUM_EN
      for (int i = 0; i < vq.size(); i++) begin
         valid_in = vq[i].vin; stream_in = vq[i].din; flush_in = vq[i].fl; m_ready = vq[i].rdy;
         tick();
         chk($sformatf("vec%0d valid", i), 32'(m_valid), 32'(vq[i].ev));
         chk($sformatf("vec%0d count", i), 32'(fifo_count), 32'(vq[i].ec));
         if (vq[i].ev) begin
            chk($sformatf("vec%0d data", i), m_data, vq[i].ed);
            chk($sformatf("vec%0d last", i), 32'(m_last), 32'(vq[i].el));
         end
      end
      valid_in = 1'b0;
`endif

      // Flush of a partial packet, then a flush with nothing buffered.
      do_reset();
      m_ready = 1'b1;
      feed(32'hA0, 5);
      flush_pulse();
      expect_packet("flush", 8'd0, 5, 32'hA0);
      chk("flush idle valid", 32'(m_valid), 32'd0);
      chk("flush idle count", 32'(fifo_count), 32'd0);
      flush_pulse();
      for (int i = 0; i < 5; i++) begin
         chk("empty flush valid", 32'(m_valid), 32'd0);
         tick();
      end

      // Backpressure on the header and mid-payload.
      do_reset();
      feed(32'h100, 16);
      stall("hdr stall", 32'hA5000010, 1'b0, 10);
      x = 32'hA5000010;
      expect_word("bp hdr", 32'hA5000010, 1'b0);
      for (int i = 0; i < 3; i++) begin
         x = x ^ (32'h100 + 32'(i));
         expect_word("bp pay", 32'h100 + 32'(i), 1'b0);
      end
      stall("pay stall", 32'h103, 1'b0, 10);
      for (int i = 3; i < 16; i++) begin
         x = x ^ (32'h100 + 32'(i));
`ifdef LWIR_PKT_CHECKSUM_EN
         expect_word("bp pay", 32'h100 + 32'(i), 1'b0);
`else
         expect_word("bp pay", 32'h100 + 32'(i), i == 15);
`endif
      end
`ifdef LWIR_PKT_CHECKSUM_EN
      expect_word("bp trl", x, 1'b1);
`endif
      chk("bp overflow", 32'(overflow), 32'd0);
      chk("bp count", 32'(fifo_count), 32'd0);

      // Overflow: 65 words into a 64-deep FIFO with the output blocked.
      do_reset();
      feed(32'd0, 65);
      chk("ovf flag", 32'(overflow), 32'd1);
      chk("ovf count", 32'(fifo_count), 32'd64);
      m_ready = 1'b1;
      for (int p = 0; p < 4; p++) expect_packet("ovf", 8'(p), 16, 32'(16 * p));
      tick();
      tick();
      chk("ovf drained valid", 32'(m_valid), 32'd0);
      chk("ovf drained count", 32'(fifo_count), 32'd0);
      chk("ovf sticky", 32'(overflow), 32'd1);

      // Asynchronous reset in the middle of a payload.
      do_reset();
      m_ready = 1'b1;
      feed(32'h200, 16);
      expect_word("rst hdr", 32'hA5000010, 1'b0);
      for (int i = 0; i < 3; i++) expect_word("rst pay", 32'h200 + 32'(i), 1'b0);
      rst_n = 1'b0;
      #1;
      chk("async rst valid", 32'(m_valid), 32'd0);
      chk("async rst count", 32'(fifo_count), 32'd0);
      tick();
      rst_n = 1'b1;
      feed(32'h500, 16);
      expect_packet("post rst", 8'd0, 16, 32'h500);

`ifdef LWIR_PKT_CHECKSUM_EN
      do_reset();
      m_ready = 1'b1;
      valid_in = 1'b1; stream_in = 32'h0000FFFF; tick();
      stream_in = 32'h12340000; tick();
      valid_in = 1'b0;
      flush_pulse();
      expect_word("ck hdr", 32'hA5000002, 1'b0);
      expect_word("ck w0", 32'h0000FFFF, 1'b0);
      expect_word("ck w1", 32'h12340000, 1'b0);
      expect_word("ck trl", 32'hB734FFFD, 1'b1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/lwir_stream_packetizer.md
Name: lwir_stream_packetizer

Overview:
- Sits directly downstream of the lossless compression core.
- Consumes its unthrottled 32-bit compressed word stream (valid_in / stream_in) and buffers it in an internal FIFO.
- Emits framed packets on a ready/valid master interface: one header word, then up to PAYLOAD_WORDS payload words.
- Absorbs output backpressure and reports any loss through a sticky overflow flag.

Parameters:
- FIFO_DEPTH, 64: buffer depth in 32-bit words; power of two, >= PAYLOAD_WORDS.
- PAYLOAD_WORDS, 16: payload words in a full packet; 1..FIFO_DEPTH.
- SYNC_BYTE, 8'hA5: header sync byte.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- valid_in  in  1  stream_in holds a word this cycle; no backpressure toward the compressor.
- stream_in  in  32  compressed word from the compression core.
- flush_in  in  1  single-cycle pulse: close the current partial packet (end of frame).
- m_valid  out  1  m_data is valid.
- m_data  out  32  header or payload word.
- m_last  out  1  final word of the packet.
- m_ready  in  1  downstream accepts the word when m_valid && m_ready.
- overflow  out  1  sticky: at least one input word was dropped.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words currently buffered.

Behaviour:
- Reset (async assert, sync release): m_valid=0, m_data=0, m_last=0, overflow=0, fifo_count=0, seq=0, flush_pending=0, state=IDLE, FIFO empty.
- Write path:
  - On valid_in, the word is written if count < FIFO_DEPTH at that edge.
  - Otherwise the word is dropped and overflow is set. This holds even if a read occurs in the same cycle.
  - Simultaneous read and write on a non-full FIFO leaves count unchanged.
- flush_in sets flush_pending. A flush arriving while flush_pending is already set has no further effect.
- Header format: {SYNC_BYTE[7:0], seq[7:0], len[15:0]}. seq increments mod 256 per emitted packet.
- State IDLE:
  - If count >= PAYLOAD_WORDS: latch len=PAYLOAD_WORDS, go to HEADER.
  - Else if flush_pending && count > 0: latch len=count, clear flush_pending, go to HEADER.
  - Else if flush_pending && count == 0: clear flush_pending, stay in IDLE.
- State HEADER: m_valid=1, m_data=header, m_last=0. On handshake go to PAYLOAD and load the word counter with len.
- State PAYLOAD:
  - m_valid=1, m_data=FIFO head (show-ahead).
  - Each handshake pops one word and decrements the counter.
  - m_last=1 when counter==1; on that handshake go to IDLE (to TRAILER if the feature is enabled) and increment seq.
- Input words arriving after a flush are not in the flushed packet unless they were already counted when len latched.
- Latency: PAYLOAD_WORDS-th word accepted at edge N -> IDLE decides in cycle N+1 -> header m_valid in cycle N+2. Minimum gap between packets is 1 IDLE cycle.
- Stability: while m_valid && !m_ready, m_data, m_last and m_valid hold. m_valid never deasserts without a handshake.
- Payload words never underflow: len is always <= count at latch time, and writes only add to the buffer.
- Reset mid-packet discards the FIFO contents and the partial packet. The output returns to m_valid=0 asynchronously.
- Pointers wrap modulo FIFO_DEPTH. Full is determined by count, not pointer equality.

Optional Feature:
- LWIR_PKT_CHECKSUM_EN defined: a TRAILER state follows PAYLOAD.
  - Trailer word = XOR of the header and all payload words of the packet.
  - m_last moves from the final payload word to the trailer.
  - seq increments on the trailer handshake.
- Undefined: no trailer, no checksum logic; m_last is on the final payload word.

Test Plan:
1. Full packet: m_ready=1; feed 16 words 0x00000001..0x00000010 -> header 0xA5000010, then the 16 words in order, m_last only on 0x00000010. Next full packet header is 0xA5010010.
2. Flush: feed 5 words 0xA0..0xA4, pulse flush_in -> header 0xA5000005, 5 words, m_last on 0xA4, then IDLE with fifo_count=0. A flush with an empty FIFO produces no output.
3. Backpressure: hold m_ready=0 for 10 cycles during the header and again mid-payload -> m_data/m_valid/m_last stable throughout. No words lost or duplicated; overflow stays 0.
4. Overflow: m_ready=0; feed 65 words 0..64 -> overflow=1, fifo_count=64. After release the output contains words 0..63 (4 packets); word 64 is absent.
5. Reset: assert rst_n=0 mid-payload (after 3 payload words) -> m_valid=0 immediately, fifo_count=0. After release, 16 new words yield header 0xA5000010.
6. With LWIR_PKT_CHECKSUM_EN: 2-word flush packet 0x0000FFFF, 0x12340000 -> header 0xA5000002, then the two words, then trailer 0xB734FFFD with m_last=1.
